// File: rtl/bridge_pkg.sv
// Shared types and constants for cpu_axi_bridge: FSM encodings, AXI IDs and constants,
// and the byte-strobe generator.
package bridge_pkg;

  typedef enum logic [1:0] {RD_IDLE, RD_AR, RD_R} rd_state_e;
  typedef enum logic [1:0] {WR_IDLE, WR_AWW, WR_B} wr_state_e;

  localparam logic [3:0] ID_INST = 4'd0;
  localparam logic [3:0] ID_DATA = 4'd1;

  localparam logic [3:0] AXI_LEN_SINGLE = 4'd0;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // Request owner encoding shared by the arbiter and the top.
  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  function automatic logic [3:0] gen_wstrb(input logic [1:0] size, input logic [1:0] addr);
    logic [3:0] strb;
    case (size)
      2'd0:    strb = 4'b0001 << addr;
      2'd1:    strb = addr[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/bridge_rd_arb.sv
// Read arbiter between the instruction and data ports. Fixed data priority by default;
// define BRIDGE_RR_ARB_EN for round-robin on ties.
module bridge_rd_arb
  import bridge_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic inst_rd,
  input  logic data_rd,
  input  logic can_accept,
  output logic grant,
  output logic owner
);

  assign grant = can_accept & (inst_rd | data_rd);

`ifdef BRIDGE_RR_ARB_EN
  logic last_grant;

  // Reset to inst so the first tie goes to the data port.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= OWN_INST;
    end else if (grant) begin
      last_grant <= owner;
    end
  end

  assign owner = (inst_rd & data_rd) ? ~last_grant : data_rd;
`else
  logic unused_rr;
  assign unused_rr = clk ^ rst;
  assign owner     = data_rd;
`endif

endmodule

// File: rtl/cpu_axi_bridge.sv
// Bridges the SRAM-like inst/data cache ports onto one single-beat AXI3 master.
// Optional BRIDGE_RR_ARB_EN selects round-robin read arbitration.
module cpu_axi_bridge #(
  parameter logic [3:0] ID_INST = bridge_pkg::ID_INST,
  parameter logic [3:0] ID_DATA = bridge_pkg::ID_DATA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);
  import bridge_pkg::*;

  rd_state_e rd_state;
  wr_state_e wr_state;
  logic      rd_owner_q;
  logic      rd_grant, rd_owner, data_rd, data_rd_busy, wr_accept, can_rd;
  logic      unused;

  assign unused = ^{inst_wr, inst_wdata, rid, rresp, bid, bresp};

  assign data_rd      = data_req & ~data_wr;
  // A data write waits for an in-flight data read so the two data_ok pulses cannot merge.
  assign data_rd_busy = (rd_state != RD_IDLE) & (rd_owner_q == OWN_DATA);
  assign wr_accept    = ~rst & data_req & data_wr & (wr_state == WR_IDLE) & ~data_rd_busy;
  assign can_rd       = ~rst & (rd_state == RD_IDLE) & (wr_state == WR_IDLE) & ~wr_accept;

  bridge_rd_arb u_rd_arb (
    .clk        (clk),
    .rst        (rst),
    .inst_rd    (inst_req),
    .data_rd    (data_rd),
    .can_accept (can_rd),
    .grant      (rd_grant),
    .owner      (rd_owner)
  );

  assign inst_addr_ok = rd_grant & (rd_owner == OWN_INST);
  assign data_addr_ok = wr_accept | (rd_grant & (rd_owner == OWN_DATA));

  assign inst_rdata   = (rd_owner_q == OWN_INST) ? rdata : '0;
  assign data_rdata   = (rd_owner_q == OWN_DATA) ? rdata : '0;
  assign inst_data_ok = rvalid & (rd_state == RD_R) & (rd_owner_q == OWN_INST);
  assign data_data_ok = (rvalid & (rd_state == RD_R) & (rd_owner_q == OWN_DATA)) |
                        (bvalid & (wr_state == WR_B));

  assign arlen   = AXI_LEN_SINGLE;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = '0;
  assign arcache = '0;
  assign arprot  = '0;
  assign awid    = ID_DATA;
  assign awlen   = AXI_LEN_SINGLE;
  assign awburst = AXI_BURST_INCR;
  assign awlock  = '0;
  assign awcache = '0;
  assign awprot  = '0;
  assign wid     = ID_DATA;
  assign wlast   = 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state   <= RD_IDLE;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      rd_owner_q <= OWN_INST;
      arid       <= '0;
      araddr     <= '0;
      arsize     <= '0;
    end else begin
      case (rd_state)
        RD_IDLE: if (rd_grant) begin
          rd_state   <= RD_AR;
          arvalid    <= 1'b1;
          rd_owner_q <= rd_owner;
          arid       <= (rd_owner == OWN_DATA) ? ID_DATA : ID_INST;
          araddr     <= (rd_owner == OWN_DATA) ? data_addr : inst_addr;
          arsize     <= {1'b0, (rd_owner == OWN_DATA) ? data_size : inst_size};
        end
        RD_AR: if (arready) begin
          rd_state <= RD_R;
          arvalid  <= 1'b0;
          rready   <= 1'b1;
        end
        RD_R: if (rvalid & rlast) begin
          rd_state <= RD_IDLE;
          rready   <= 1'b0;
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state <= WR_IDLE;
      awvalid  <= 1'b0;
      wvalid   <= 1'b0;
      bready   <= 1'b0;
      awaddr   <= '0;
      awsize   <= '0;
      wdata    <= '0;
      wstrb    <= '0;
    end else begin
      case (wr_state)
        WR_IDLE: if (wr_accept) begin
          wr_state <= WR_AWW;
          awvalid  <= 1'b1;
          wvalid   <= 1'b1;
          awaddr   <= data_addr;
          awsize   <= {1'b0, data_size};
          wdata    <= data_wdata;
          wstrb    <= gen_wstrb(data_size, data_addr[1:0]);
        end
        WR_AWW: begin
          if (awvalid & awready) awvalid <= 1'b0;
          if (wvalid & wready) wvalid <= 1'b0;
          if ((~awvalid | awready) & (~wvalid | wready)) begin
            wr_state <= WR_B;
            bready   <= 1'b1;
          end
        end
        WR_B: if (bvalid) begin
          wr_state <= WR_IDLE;
          bready   <= 1'b0;
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Directed bench for cpu_axi_bridge with a small gated AXI slave model.
module tb_cpu_axi_bridge;

`ifdef BRIDGE_RR_ARB_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk, rst;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic [31:0] inst_rdata, data_rdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [3:0]  arid, arlen, arcache, awid, awlen, awcache, wid, wstrb, rid, bid;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [2:0]  arsize, arprot, awsize, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  // Slave model: responses are pending flags, exposed only while the bench opens a gate.
  logic        r_gate, b_gate, slave_rst, r_pend, b_pend, aw_seen, w_seen;
  logic [31:0] r_word;
  int          b_count;
  int          errors = 0;
  int          checks = 0;
  int          b_base;

  assign rvalid = r_pend & r_gate;
  assign bvalid = b_pend & b_gate;
  assign rdata  = r_word;
  assign rlast  = 1'b1;
  assign rid    = 4'd0;
  assign rresp  = 2'd0;
  assign bid    = 4'd1;
  assign bresp  = 2'd0;

  cpu_axi_bridge dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (slave_rst) begin
      r_pend  <= 1'b0;
      b_pend  <= 1'b0;
      aw_seen <= 1'b0;
      w_seen  <= 1'b0;
      b_count <= 0;
    end else begin
      if (rvalid & rready) r_pend <= 1'b0;
      else if (arvalid & arready) r_pend <= 1'b1;
      if (bvalid & bready) begin
        b_pend  <= 1'b0;
        b_count <= b_count + 1;
      end else if ((aw_seen | (awvalid & awready)) & (w_seen | (wvalid & wready))) begin
        b_pend  <= 1'b1;
        aw_seen <= 1'b0;
        w_seen  <= 1'b0;
      end else begin
        if (awvalid & awready) aw_seen <= 1'b1;
        if (wvalid & wready) w_seen <= 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; slave_rst = 1'b1;
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = '0; inst_wdata = '0;
    data_req = 1; data_wr = 0; data_size = 2'd2; data_addr = '0; data_wdata = '0;
    arready = 1; awready = 1; wready = 1; r_gate = 1; b_gate = 0; r_word = 32'hDEADBEEF;

    // Reset: request held high must not be acknowledged.
    repeat (2) step();
    #1;
    check("rst_valid_ready", {arvalid, awvalid, wvalid, rready, bready}, 5'b0);
    check("rst_oks", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 4'b0);
    data_req = 0;
    rst = 0; slave_rst = 0;

    // Data read, zero-wait slave.
    step();
    data_req = 1; data_wr = 0; data_size = 2'd2; data_addr = 32'h1000_0004; #1;
    check("rd_addr_ok", {inst_addr_ok, data_addr_ok}, 2'b01);
    step();
    data_req = 0; #1;
    check("rd_arvalid", arvalid, 1'b1);
    check("rd_arid", arid, 4'd1);
    check("rd_araddr", araddr, 32'h1000_0004);
    check("rd_arsize_len_burst", {arsize, arlen, arburst}, {3'd2, 4'd0, 2'b01});
    step(); #1;
    check("rd_data_ok", {inst_data_ok, data_data_ok, rready}, 3'b011);
    check("rd_rdata", data_rdata, 32'hDEADBEEF);
    step(); #1;
    check("rd_done", {data_data_ok, rready, arvalid}, 3'b000);

    // Data byte write at lane 2; B held off by the slave.
    b_base = b_count;
    data_req = 1; data_wr = 1; data_size = 2'd0; data_addr = 32'h2000_0002;
    data_wdata = 32'h00AB_0000; #1;
    check("wr_addr_ok", data_addr_ok, 1'b1);
    step();
    data_req = 0; data_wr = 0; #1;
    check("wr_valids", {awvalid, wvalid}, 2'b11);
    check("wr_wstrb", wstrb, 4'b0100);
    check("wr_len_last_size", {awlen, wlast, awsize}, {4'd0, 1'b1, 3'd0});
    check("wr_awaddr_wdata", {awaddr ^ 32'h2000_0002, wdata}, {32'd0, 32'h00AB_0000});
    step(); #1;
    check("wr_b_wait0", {data_data_ok, bready, awvalid, wvalid}, 4'b0100);
    step(); #1;
    check("wr_b_wait1", data_data_ok, 1'b0);
    b_gate = 1; #1;
    check("wr_b_ok", data_data_ok, 1'b1);
    step();
    b_gate = 0; #1;
    check("wr_b_done", {bready, data_data_ok}, 2'b00);
    check("wr_b_count", b_count - b_base, 1);

    // Read tie: data wins first; second tie follows the arbitration mode.
    r_word = 32'h1111_1111;
    inst_req = 1; inst_size = 2'd2; inst_addr = 32'h0000_0100;
    data_req = 1; data_wr = 0; data_size = 2'd2; data_addr = 32'h0000_0200; #1;
    check("tie1_grant", {inst_addr_ok, data_addr_ok}, 2'b01);
    step(); #1;
    check("tie1_ar", {arid, araddr}, {4'd1, 32'h0000_0200});
    check("tie1_busy_ok", {inst_addr_ok, data_addr_ok}, 2'b00);
    step(); #1;
    check("tie1_rdata", {data_data_ok, inst_data_ok, inst_addr_ok}, 3'b100);
    check("tie1_word", data_rdata, 32'h1111_1111);
    r_word = 32'h2222_2222;
    step(); #1;
    check("tie2_inst_ok", inst_addr_ok, RR);
    check("tie2_data_ok", data_addr_ok, !RR);
    step();
    data_req = 0; #1;
    check("tie2_arid", arid, RR ? 32'd0 : 32'd1);
    step(); #1;
    check("tie2_inst_data_ok", inst_data_ok, RR);
    check("tie2_data_data_ok", data_data_ok, !RR);
    check("tie2_inst_rdata", inst_rdata, RR ? 32'h2222_2222 : 32'd0);
    check("tie2_data_rdata", data_rdata, RR ? 32'd0 : 32'h2222_2222);
    step();
    r_word = 32'h3333_3333; #1;
    check("tie_inst_accept", {inst_addr_ok, data_addr_ok}, 2'b10);
    step();
    inst_req = 0; #1;
    check("tie_inst_ar", {arid, araddr}, {4'd0, 32'h0000_0100});
    step(); #1;
    check("tie_inst_ok", {inst_data_ok, data_data_ok}, 2'b10);
    check("tie_inst_rdata", inst_rdata, 32'h3333_3333);

    // Halfword write with AW ready two cycles before W; inst read waits for WR_IDLE.
    step();
    b_base = b_count;
    awready = 1; wready = 0; b_gate = 1;
    data_req = 1; data_wr = 1; data_size = 2'd1; data_addr = 32'h3000_0002;
    data_wdata = 32'h1234_0000;
    inst_req = 1; inst_wr = 1; inst_addr = 32'h0000_0400; #1;
    check("raw_accept", {inst_addr_ok, data_addr_ok}, 2'b01);
    step();
    data_req = 0; data_wr = 0; #1;
    check("split_valids", {awvalid, wvalid, inst_addr_ok}, 3'b110);
    check("split_wstrb_size", {wstrb, awsize}, {4'b1100, 3'd1});
    step(); #1;
    check("split_aw_dropped", {awvalid, wvalid, inst_addr_ok}, 3'b010);
    check("split_wdata_hold", wdata, 32'h1234_0000);
    step();
    wready = 1; #1;
    check("split_w_held", {awvalid, wvalid, inst_addr_ok}, 3'b010);
    step(); #1;
    check("split_b", {wvalid, bready, data_data_ok, inst_addr_ok}, 4'b0110);
    step(); #1;
    check("raw_inst_ok", {inst_addr_ok, bready}, 2'b10);
    check("split_b_count", b_count - b_base, 1);
    step();
    inst_req = 0; inst_wr = 0; b_gate = 0; r_gate = 0; #1;
    check("raw_ar", {arvalid, arid, araddr}, {1'b1, 4'd0, 32'h0000_0400});
    step(); #1;
    check("rst_mid_pre", {rready, inst_data_ok}, 2'b10);

    // Reset while in RD_R abandons the read.
    rst = 1;
    step();
    r_gate = 1; #1;
    check("rst_mid_valid_ready", {arvalid, awvalid, wvalid, rready, bready}, 5'b0);
    check("rst_mid_no_ok", {inst_data_ok, data_data_ok}, 2'b00);
    rst = 0;
    step(); #1;
    check("rst_mid_after", {inst_data_ok, rready}, 2'b00);
    slave_rst = 1;
    step();
    slave_rst = 0; r_gate = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_axi_bridge.md
# cpu_axi_bridge

Converts the two SRAM-like cache-side master ports (instruction cache, data cache) into a single AXI3 master for the memory subsystem. Sits directly downstream of the data cache and instruction cache and consumes their `req/wr/size/addr/wdata` requests. It arbitrates between the two ports and issues single-beat AXI transactions. It returns `addr_ok`, `data_ok` and `rdata` to the port that issued each request.

## Interface
Parameters:
- `ID_INST`, 0: AXI ID used for instruction-port reads.
- `ID_DATA`, 1: AXI ID used for data-port reads and writes.

Clock and reset: reset `rst`, synchronous, active-high; clock `clk`.

Ports:
- `inst_req/inst_wr/inst_size/inst_addr/inst_wdata`, in, 1/1/2/32/32: instruction-side request. Read-only; `inst_wr` must be 0 and is ignored.
- `inst_rdata/inst_addr_ok/inst_data_ok`, out, 32/1/1: instruction-side response.
- `data_req/data_wr/data_size/data_addr/data_wdata`, in, 1/1/2/32/32: data-side request.
- `data_rdata/data_addr_ok/data_data_ok`, out, 32/1/1: data-side response.
- `arid/araddr/arlen/arsize/arburst/arvalid`, out, 4/32/4/3/2/1: AR channel. `arready` in 1.
- `rid/rdata/rresp/rlast/rvalid`, in, 4/32/2/1/1: R channel. `rready` out 1.
- `awid/awaddr/awlen/awsize/awburst/awvalid`, out, 4/32/4/3/2/1: AW channel. `awready` in 1.
- `wid/wdata/wstrb/wlast/wvalid`, out, 4/32/4/1/1: W channel. `wready` in 1.
- `bid/bresp/bvalid`, in, 4/2/1: B channel. `bready` out 1.
- `arlock/arcache/arprot/awlock/awcache/awprot`, out, 2/4/3 each: tied to 0.

## Operation
- Single beat only: `arlen=awlen=0`, `arburst=awburst=2'b01`, `wlast=1`. `arsize`/`awsize` = `{1'b0,size}`.
- Address is forwarded unmodified. `wstrb` is derived from size and `addr[1:0]`:
  - size 0: one-hot byte lane at `addr[1:0]`.
  - size 1: `addr[1]` ? `4'b1100` : `4'b0011`.
  - size 2: `4'b1111`.
- Read FSM has states RD_IDLE, RD_AR, RD_R:
  - RD_IDLE→RD_AR on an accepted read.
  - RD_AR→RD_R on `arvalid&arready`.
  - RD_R→RD_IDLE on `rvalid&rready&rlast`.
- Write FSM has states WR_IDLE, WR_AWW, WR_B:
  - In WR_AWW, `awvalid` and `wvalid` are independent. Each drops after its own handshake; both may complete in the same cycle.
  - WR_AWW→WR_B once both handshakes are done.
  - WR_B→WR_IDLE on `bvalid&bready`.
- Acceptance: a read is accepted only when the read FSM is RD_IDLE and the write FSM is WR_IDLE. This is a conservative read-after-write hazard guard. A write is accepted only when the write FSM is WR_IDLE.
- Arbitration: when both ports request a read in the same cycle, the data port wins. A data write plus an instruction read in the same cycle: the write is accepted and the instruction read waits until WR_IDLE.
- Accepted request: the address, size, wdata and owner (inst/data) are latched and `<port>_addr_ok` pulses in the acceptance cycle. At most one read and one write are outstanding.
- Read return: `rdata` is passed combinationally to `<owner>_rdata`, and `<owner>_data_ok = rvalid & (state==RD_R)`. `rresp` is ignored. An `rid` that does not match the latched owner is treated as the latched owner.
- Write completion: `data_data_ok = bvalid & (state==WR_B)`.
- `rready` is 1 only in RD_R. `bready` is 1 only in WR_B.

## Timing
- Reset: all `*valid`, `rready`, `bready`, `*_addr_ok` and `*_data_ok` are 0. Both FSMs are in IDLE.
- Reset mid-transaction abandons the transaction with no response to the cache.
- `addr_ok` is combinational in the request cycle when acceptance conditions hold.
- AR/AW/W valid assert one cycle after acceptance.
- Minimum read latency, `req` to `data_ok`, is 3 cycles: accept, AR handshake, R beat with 0-wait slave.
- Minimum write latency is 3 cycles: accept, AW+W handshake, B beat.
- Valid signals hold their address and data stable until ready, per AXI.
- `addr_ok` never asserts for a port whose previous request is still outstanding in the same direction.

## Configuration
- `BRIDGE_RR_ARB_EN` defined: the read arbiter is round-robin. A 1-bit `last_grant` register is updated on each accepted read, and the port not granted last wins a tie.
- Undefined: fixed data-port priority, as described above.

## Structure
- Shared package `bridge_pkg`: FSM state encodings, `ID_INST`/`ID_DATA`, burst/len constants, and the `wstrb` generation function.
- One sub-module, `bridge_rd_arb`: read arbitration with the optional round-robin state, outputting grant and owner.

## Test plan
- Data read `addr=0x1000_0004`, `size=2`, slave `rdata=0xDEADBEEF` with 0 wait → `arid=1`, `arsize=2`; `data_data_ok` pulses 3 cycles after the request with `data_rdata=0xDEADBEEF`; `inst_data_ok` stays 0.
- Data write of byte `0xAB` at `addr=0x...02`, `size=0` → `wstrb=4'b0100`, `awlen=0`, `wlast=1`. `data_data_ok` does not assert until `bvalid`.
- Simultaneous `inst_req` and `data_req` reads, macro undefined → data granted first and the inst request is accepted after RD_IDLE. With `BRIDGE_RR_ARB_EN`, a second tie goes to inst.
- `awready` 2 cycles before `wready` → `awvalid` drops independently, `wvalid` held stable until `wready`, then one B accepted.
- Data write pending in WR_B while `inst_req` read is asserted → `inst_addr_ok=0` until the B handshake; then the read proceeds.
- Assert `rst` while in RD_R → all valids and readys go 0 the next cycle and no `data_ok` is issued.
